// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: per-slot dead time, frame-synchronous data update,
// leading-zero suppression, per-digit blanking/DP. Optional blink feature enabled by macro SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int DIV_CYCLES     = 6250,
    parameter int DEAD_CYCLES    = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic [NUM_DIGITS-1:0]   iBLANK,
    input  logic                    iLZS,
    input  logic                    iLOAD,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   iBLINK,
`endif
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oDIG,
    output logic                    oFRAME
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic                  SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic                  DIG_LOW = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{SEG_LOW}};
    localparam logic                  DP_OFF  = SEG_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_LOW}};

    localparam logic [0:0] ST_GAP  = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [0:0]              state;
    logic [CW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;

    logic [4*NUM_DIGITS-1:0] sh_data, ds_data;
    logic [NUM_DIGITS-1:0]   sh_dp, ds_dp;
    logic [NUM_DIGITS-1:0]   sh_blank, ds_blank;
    logic                    sh_lzs, ds_lzs;

    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NUM_DIGITS-1:0]   dark;
    logic [NUM_DIGITS-1:0]   dig_hot;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_dark;
    logic [6:0]              next_seg;
    logic                    next_dp;
    logic [NUM_DIGITS-1:0]   next_dig;

`ifdef SEG7_BLINK_EN
    logic [NUM_DIGITS-1:0]   sh_blink, ds_blink;
    logic [7:0]              frame_cnt;
    logic                    blink_phase;

    assign blink_mask = blink_phase ? ds_blink : '0;
`else
    assign blink_mask = '0;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1100111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            4'hF: glyph = 7'b1110001;
        endcase
    endfunction

    // upper_zero[k] is set when nibbles k..NUM_DIGITS-1 of the displayed value are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (ds_data[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (ds_data[4*k +: 4] == 4'h0);
        end
    end

    assign dark    = ds_blank | blink_mask
                   | ({upper_zero[NUM_DIGITS-1:1], 1'b0} & {NUM_DIGITS{ds_lzs}});
    assign dig_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib  = ds_data[4*k +: 4];
                cur_dp   = ds_dp[k];
                cur_dark = dark[k];
            end
        end
    end

    assign next_seg = cur_dark ? SEG_OFF : (glyph(cur_nib) ^ {7{SEG_LOW}});
    assign next_dp  = (cur_dp && !cur_dark) ? ~DP_OFF : DP_OFF;
    assign next_dig = dig_hot ^ {NUM_DIGITS{DIG_LOW}};

    // Scan FSM: the slot counter runs over the whole slot; the GAP->SHOW and SHOW->GAP edges load
    // the registered pins, and the wrap back to digit 0 commits the shadow into the display copy.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= ST_GAP;
            slot_cnt <= '0;
            idx      <= '0;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lzs   <= 1'b0;
            ds_data  <= '0;
            ds_dp    <= '0;
            ds_blank <= '0;
            ds_lzs   <= 1'b0;
            oSEG     <= SEG_OFF;
            oDP      <= DP_OFF;
            oDIG     <= DIG_OFF;
            oFRAME   <= 1'b0;
`ifdef SEG7_BLINK_EN
            sh_blink    <= '0;
            ds_blink    <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
`endif
        end else begin
            oFRAME <= 1'b0;
            if (iLOAD) begin
                sh_data  <= iDATA;
                sh_dp    <= iDP;
                sh_blank <= iBLANK;
                sh_lzs   <= iLZS;
`ifdef SEG7_BLINK_EN
                sh_blink <= iBLINK;
`endif
            end
            if (state == ST_GAP && slot_cnt == DEAD_LAST) begin
                state    <= ST_SHOW;
                slot_cnt <= slot_cnt + 1'b1;
                oSEG     <= next_seg;
                oDP      <= next_dp;
                oDIG     <= next_dig;
            end else if (state == ST_SHOW && slot_cnt == SLOT_LAST) begin
                state    <= ST_GAP;
                slot_cnt <= '0;
                oSEG     <= SEG_OFF;
                oDP      <= DP_OFF;
                oDIG     <= DIG_OFF;
                if (idx == IDX_LAST) begin
                    idx      <= '0;
                    ds_data  <= sh_data;
                    ds_dp    <= sh_dp;
                    ds_blank <= sh_blank;
                    ds_lzs   <= sh_lzs;
                    oFRAME   <= 1'b1;
`ifdef SEG7_BLINK_EN
                    ds_blink  <= sh_blink;
                    frame_cnt <= frame_cnt + 8'd1;
                    if (frame_cnt == 8'hFF) begin
                        blink_phase <= ~blink_phase;
                    end
`endif
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for N common-anode 7-segment digits sharing one segment bus.
- Next generation of the static per-digit hex decoder: same 0–F glyph set, one shared decoder, scanned digit enables.
- Adds anti-ghosting dead time, frame-synchronous data update, leading-zero suppression, per-digit blanking and decimal points.
- Sits between the display-data register file and the board segment/digit pins.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (2..16)
- DIV_CYCLES, 6250, clock cycles per digit slot (50 MHz / 8 / 1 kHz frame)
- DEAD_CYCLES, 64, cycles at slot start with all digits off; must satisfy 1 <= DEAD_CYCLES < DIV_CYCLES
- SEG_ACTIVE_LOW, 1, 1 = segment/DP lit when 0
- DIG_ACTIVE_LOW, 1, 1 = digit enable asserted when 0

Ports:
- iCLK  input  1  system clock
- iRST  input  1  reset; one clock; asynchronous, active-high
- iDATA  input  4*NUM_DIGITS  hex nibble per digit; nibble k drives digit k; digit 0 is least significant
- iDP  input  NUM_DIGITS  decimal point per digit, 1 = lit
- iBLANK  input  NUM_DIGITS  1 = digit forced dark, including its DP
- iLZS  input  1  leading-zero suppression enable
- iLOAD  input  1  single-cycle strobe; captures iDATA/iDP/iBLANK/iLZS into the shadow register
- oSEG  output  7  segments g..a on bits 6..0
- oDP  output  1  decimal point
- oDIG  output  NUM_DIGITS  one-hot digit enable
- oFRAME  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, while iRST=1):
  - Shadow and display registers are 0; slot counter is 0; digit index is 0; state is GAP.
  - oSEG, oDP and oDIG are all inactive (all-ones when active-low). oFRAME is 0.
- Shadow capture: on any rising edge with iLOAD=1, the shadow register takes the inputs. With several loads in one frame, the last one wins.
- State machine (advances on the slot counter):
  - GAP: lasts DEAD_CYCLES cycles; oDIG, oSEG and oDP are inactive. Then go to SHOW.
  - SHOW: lasts DIV_CYCLES-DEAD_CYCLES cycles; oDIG asserts only bit idx; oSEG/oDP show digit idx. Then go to GAP with idx+1.
  - Wrap: idx NUM_DIGITS-1 wraps to 0. On the edge that enters GAP for idx 0, the display register copies the shadow and oFRAME pulses high for exactly that cycle.
  - First frame after reset starts at GAP for idx 0. No oFRAME pulse in that first cycle; the display register stays 0.
- All outputs are registered. Each changes on the edge that enters the new state.
- Glyphs (active-high form, g..a; inverted when SEG_ACTIVE_LOW=1):
  - 0–7: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8–F: 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Digit dark rule: digit k is dark when its display-register blank bit is 1, or when suppression applies (below).
  - Suppression applies when latched LZS=1, k>0, and nibbles k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - A dark digit keeps its oDIG bit asserted in its SHOW slot, with oSEG and oDP inactive.
- iLOAD in the same cycle as a frame wrap: the display register takes the previous shadow. The new value appears at the next frame.
- iRST mid-operation: outputs go inactive in the same cycle, asynchronously.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- Defined:
  - Adds input iBLINK [NUM_DIGITS-1:0], latched with iLOAD.
  - A phase bit toggles every 256 frames, counted by oFRAME pulses. Counter and phase reset to 0.
  - When the phase is 1, digits with their blink bit set are dark.
- Undefined:
  - No iBLINK port and no blink counter.
  - Behaviour is identical to a build with blink bits all 0.

Test Plan (NUM_DIGITS=4, DIV_CYCLES=10, DEAD_CYCLES=2, both active-low):
- Reset, then release → oDIG=1111 and oSEG=1111111 for 2 cycles; then oDIG=1110 for 8 cycles, oSEG=1000000 (value 0); oFRAME first pulses 40 cycles after release.
- iLOAD with iDATA=16'h12AF, iLZS=0 mid-frame → current frame still shows 0000. Next frame shows:
  - digit 0 = 0001110, digit 1 = 0001000, digit 2 = 0100100, digit 3 = 1111001
  - oFRAME period is exactly 40 cycles.
- iLZS=1, iDATA=16'h0050 → digits 3 and 2 have oSEG=1111111, digit 1 = 0010010, digit 0 = 1000000. With iDATA=16'h0000 → only digit 0 lit, showing 1000000.
- Two iLOADs in one frame (16'h1111, then 16'h2222); a further load coincident with the oFRAME edge → next frame shows 2222; the coincident value appears one frame later.
- iBLANK=0100, iDP=0101 → digit 2 is fully dark (oDP=1, inactive); digit 0 has oDP=0; assert iRST during a SHOW slot → oDIG=1111 in the same cycle.
- SEG7_BLINK_EN defined, iBLINK=0001 → digit 0 lit for frames 0–255, dark for frames 256–511, lit again from frame 512.
